// File: rtl/instr_fetch.sv
// Fetch sequencer for proc: reads ROM words, pulses Run per instruction, supplies mvi immediates.
// Run 3 cycles after Start (4 for mvi); stalls in EXEC on Done, watchdog faults after TIMEOUT cycles.
module instr_fetch #(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = (1 << ADDR_W) - 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic              Fault
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, IMM, ISSUE, EXEC, HALT, FAULT} state_t;

    localparam int               WD_W     = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  LAST_EXT = (ADDR_W + 1)'(LAST_ADDR);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]       OP_MVI   = 3'b001;

    state_t            state;
    logic [15:0]       instr_reg;
    logic [15:0]       imm_reg;
    logic [WD_W-1:0]   wdog;
    logic              is_mvi;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W:0]   pc_ext;
    logic [ADDR_W:0]   pc_end;
    logic              last_hit;

    assign is_mvi  = (instr_reg[8:6] == OP_MVI);
    assign pc_next = PC + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));

    // Unwrapped span of the current instruction, so an mvi at the top address still covers LAST_ADDR.
    assign pc_ext   = {1'b0, PC};
    assign pc_end   = pc_ext + {{ADDR_W{1'b0}}, is_mvi};
    assign last_hit = (pc_ext <= LAST_EXT) && (LAST_EXT <= pc_end);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            PC        <= '0;
            MemAddr   <= '0;
            DIN       <= '0;
            Run       <= 1'b0;
            Halted    <= 1'b0;
            Fault     <= 1'b0;
            instr_reg <= '0;
            imm_reg   <= '0;
            wdog      <= '0;
        end else begin
            Run <= 1'b0;
            case (state)
                IDLE: begin
                    MemAddr <= PC;
                    if (Start) state <= FETCH;
                end
                FETCH: begin
                    // ROM is one cycle behind the address, so LOAD sees ROM[PC] while PC+1 is requested.
                    MemAddr <= PC + ADDR_W'(1);
                    state   <= LOAD;
                end
                LOAD: begin
                    instr_reg <= MemData;
                    if (MemData[8:6] == OP_MVI) begin
                        state <= IMM;
                    end else begin
                        DIN   <= MemData;
                        Run   <= 1'b1;
                        state <= ISSUE;
                    end
                end
                IMM: begin
                    imm_reg <= MemData;
                    DIN     <= instr_reg;
                    Run     <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    DIN   <= is_mvi ? imm_reg : instr_reg;
                    wdog  <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    if (Done) begin
                        PC      <= pc_next;
                        MemAddr <= pc_next;
                        if (last_hit) begin
                            state  <= HALT;
                            Halted <= 1'b1;
                        end else if (Start) begin
                            state <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wdog == WD_LIMIT) begin
                        state <= FAULT;
                        Fault <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                HALT, FAULT: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (LAST_ADDR=31 and 3) run the same ROM and Done timing in lockstep.
module tb_instr_fetch;
    localparam int AW    = 5;
    localparam int NW    = 1 << AW;
    localparam int MAXI  = 64;
    localparam int LAST0 = NW - 1;
    localparam int LAST1 = 3;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Start;
    logic [AW-1:0] mem_addr [2];
    logic [15:0]   mem_data [2];
    logic [15:0]   din      [2];
    logic          run      [2];
    logic          done     [2];
    logic [AW-1:0] pc       [2];
    logic          halted   [2];
    logic          fault    [2];

    always #5 Clock = ~Clock;

    instr_fetch #(.ADDR_W(AW)) u_dut0 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .MemAddr(mem_addr[0]),
        .MemData(mem_data[0]), .DIN(din[0]), .Run(run[0]), .Done(done[0]),
        .PC(pc[0]), .Halted(halted[0]), .Fault(fault[0])
    );

    instr_fetch #(.ADDR_W(AW), .LAST_ADDR(LAST1)) u_dut1 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .MemAddr(mem_addr[1]),
        .MemData(mem_data[1]), .DIN(din[1]), .Run(run[1]), .Done(done[1]),
        .PC(pc[1]), .Halted(halted[1]), .Fault(fault[1])
    );

    logic [15:0]   rom [NW];
    int            lat [MAXI];
    int            cyc, s0, vectors, miscompares;

    int            nrun [2], evt [2], unstable [2], rcyc [2];
    bit            in_exec [2];
    logic [AW-1:0] prev_addr [2];
    int            obs_r  [2][MAXI];
    logic [15:0]   obs_di [2][MAXI];
    logic [15:0]   obs_de [2][MAXI];

    int            exp_n [2], exp_evt [2];
    int            exp_r  [2][MAXI];
    logic [15:0]   exp_di [2][MAXI];
    logic [15:0]   exp_de [2][MAXI];
    int            mpc [2];
    bit            mhalt [2], mfault [2];
    logic [15:0]   mdin [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: synchronous ROM, Done responder, observation of Run / DIN / flags.
    task automatic step();
        @(negedge Clock);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            mem_data[d]  = rom[prev_addr[d]];
            prev_addr[d] = mem_addr[d];
            done[d]      = 1'b0;
            if ((halted[d] || fault[d]) && evt[d] < 0) evt[d] = cyc - s0;
            if (run[d]) begin
                if (nrun[d] < MAXI) begin
                    obs_r[d][nrun[d]]  = cyc - s0;
                    obs_di[d][nrun[d]] = din[d];
                end
                nrun[d]++;
                rcyc[d]    = cyc;
                in_exec[d] = 1'b1;
            end else if (in_exec[d] && nrun[d] <= MAXI) begin
                int j;
                j = cyc - rcyc[d];
                if (j == 1) obs_de[d][nrun[d]-1] = din[d];
                else if (din[d] !== obs_de[d][nrun[d]-1]) unstable[d]++;
                if (j == lat[nrun[d]-1]) begin
                    done[d]    = 1'b1;
                    in_exec[d] = 1'b0;
                end else if (j >= 16) begin
                    in_exec[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        Resetn = 1'b0;
        Start  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_exec[d] = 1'b0; done[d] = 1'b0; nrun[d] = 0; evt[d] = -1;
            mpc[d] = 0; mhalt[d] = 1'b0; mfault[d] = 1'b0; mdin[d] = '0;
        end
        repeat (n) step();
        Resetn = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d PC", tag, d), 32'(pc[d]), 0);
            check($sformatf("%s d%0d MemAddr", tag, d), 32'(mem_addr[d]), 0);
            check($sformatf("%s d%0d DIN", tag, d), 32'(din[d]), 0);
            check($sformatf("%s d%0d Run", tag, d), 32'(run[d]), 0);
            check($sformatf("%s d%0d Halted", tag, d), 32'(halted[d]), 0);
            check($sformatf("%s d%0d Fault", tag, d), 32'(fault[d]), 0);
        end
    endtask

    // mode 0: never mvi, 1: mvi about one time in three, 2: always mvi
    function automatic logic [15:0] rand_word(input int mode);
        logic [15:0] w;
        w = 16'($urandom);
        if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) w[8:6] = 3'b001;
        else if (w[8:6] == 3'b001) w[8:6] = 3'b000;
        return w;
    endfunction

    task automatic fill_rom(input int mode);
        for (int i = 0; i < NW; i++) rom[i] = rand_word(mode);
    endtask

    task automatic fill_lat(input bit allow_fault);
        for (int i = 0; i < MAXI; i++)
            lat[i] = (allow_fault && $urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
    endtask

    // Instruction-level reference: walks the program, timing each Run from Start/Done.
    task automatic model(input int d, input int last, input int stop_after);
        int pc_u, t_base, t, n, l, len;
        logic [15:0] ins;
        bit mvi;
        n = 0;
        exp_evt[d] = -1;
        if (mhalt[d] || mfault[d]) begin
            exp_n[d] = 0;
            exp_evt[d] = 1;
            return;
        end
        pc_u = mpc[d];
        t_base = 3;
        while (n < MAXI) begin
            ins = rom[pc_u];
            mvi = (ins[8:6] == 3'b001);
            len = mvi ? 2 : 1;
            t = t_base + len - 1;
            exp_r[d][n]  = t;
            exp_di[d][n] = ins;
            exp_de[d][n] = mvi ? rom[(pc_u + 1) % NW] : ins;
            mdin[d] = exp_de[d][n];
            l = lat[n];
            n++;
            if (l < 1 || l > 15) begin
                mfault[d] = 1'b1;
                exp_evt[d] = t + 16;
                break;
            end
            if (pc_u <= last && last <= pc_u + len - 1) begin
                mhalt[d] = 1'b1;
                exp_evt[d] = t + l + 1;
                pc_u = (pc_u + len) % NW;
                break;
            end
            pc_u = (pc_u + len) % NW;
            if (n == stop_after) break;
            t_base = t + l + 3;
        end
        mpc[d] = pc_u;
        exp_n[d] = n;
    endtask

    task automatic run_prog(input int stop_after);
        int budget;
        model(0, LAST0, stop_after);
        model(1, LAST1, stop_after);
        budget = 10;
        for (int d = 0; d < 2; d++) begin
            if (exp_n[d] > 0 && exp_r[d][exp_n[d]-1] + 25 > budget) budget = exp_r[d][exp_n[d]-1] + 25;
            nrun[d] = 0; evt[d] = -1; unstable[d] = 0; in_exec[d] = 1'b0;
        end
        s0 = cyc;
        Start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            step();
            if (stop_after > 0 && nrun[0] == stop_after && cyc == rcyc[0] + 1) Start = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d run count", d), nrun[d], exp_n[d]);
            for (int i = 0; i < exp_n[d] && i < nrun[d]; i++) begin
                check($sformatf("d%0d run%0d cycle", d, i), obs_r[d][i], exp_r[d][i]);
                check($sformatf("d%0d run%0d DIN issue", d, i), 32'(obs_di[d][i]), 32'(exp_di[d][i]));
                check($sformatf("d%0d run%0d DIN exec", d, i), 32'(obs_de[d][i]), 32'(exp_de[d][i]));
            end
            check($sformatf("d%0d DIN changes in EXEC", d), unstable[d], 0);
            check($sformatf("d%0d PC", d), 32'(pc[d]), mpc[d]);
            check($sformatf("d%0d Halted", d), 32'(halted[d]), 32'(mhalt[d]));
            check($sformatf("d%0d Fault", d), 32'(fault[d]), 32'(mfault[d]));
            check($sformatf("d%0d flag cycle", d), evt[d], exp_evt[d]);
            if (mhalt[d] || mfault[d]) check($sformatf("d%0d DIN held", d), 32'(din[d]), 32'(mdin[d]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        Resetn = 1'b0; Start = 1'b0;
        cyc = 0; s0 = 0; vectors = 0; miscompares = 0;
        for (int i = 0; i < NW; i++) rom[i] = '0;
        for (int d = 0; d < 2; d++) begin
            prev_addr[d] = '0; mem_data[d] = '0; done[d] = 1'b0;
        end

        // Reset, then idle with Start low
        do_reset(2);
        check_reset("reset");
        repeat (12) step();
        check("idle no Run d0", nrun[0], 0);
        check("idle no Run d1", nrun[1], 0);
        check_reset("idle");

        // One-word launch, Done one cycle after Run
        fill_rom(0); rom[0] = 16'h0008;
        fill_lat(0); lat[0] = 1;
        run_prog(1);

        // mvi followed by a one-word instruction at address 2
        do_reset(1);
        fill_rom(1); rom[0] = 16'h0040; rom[1] = 16'h1234; rom[2] = rand_word(0);
        fill_lat(0);
        run_prog(2);

        // Program end with one-word code: d1 halts after 4, d0 after 32
        do_reset(1);
        fill_rom(0); fill_lat(0);
        run_prog(0);

        // Program end on mvi at 3 (d1) and at 31 with wrapped immediate (d0)
        do_reset(1);
        fill_rom(1);
        for (int i = 0; i < 3; i++) rom[i] = rand_word(0);
        rom[3] = rand_word(2); rom[30] = rand_word(0); rom[31] = rand_word(2);
        fill_lat(0);
        run_prog(0);

        // Reset while halted, then refetch from address 0
        do_reset(1);
        check_reset("reset in HALT");
        fill_lat(0);
        run_prog(1);

        // Watchdog: no Done faults; Done in cycle 15 completes
        do_reset(1);
        fill_rom(1); fill_lat(0); lat[0] = 0;
        run_prog(0);
        do_reset(1);
        fill_lat(0); lat[0] = 15;
        run_prog(1);

        // Start dropped during EXEC of the third instruction, then restarted from IDLE
        do_reset(1);
        fill_rom(1);
        for (int i = 0; i < 3; i++) rom[i] = rand_word(0);
        fill_lat(0);
        run_prog(3);
        fill_lat(0);
        run_prog(0);

        // Reset in the middle of EXEC
        do_reset(1);
        fill_rom(1); fill_lat(0); lat[0] = 15;
        s0 = cyc; Start = 1'b1;
        w = 0;
        while (!run[0] && w < 10) begin
            step();
            w++;
        end
        check("Run before mid-EXEC reset", 32'(run[0]), 1);
        repeat (3) step();
        do_reset(1);
        check_reset("reset in EXEC");
        fill_lat(0);
        run_prog(2);

        // Random programs with random Done latencies and occasional timeouts
        for (int r = 0; r < 4; r++) begin
            do_reset(1);
            fill_rom(1); fill_lat(1);
            run_prog(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that sits directly upstream of the `proc` datapath. It reads 16-bit instruction words from a synchronous instruction ROM and presents them on the processor's `DIN`. It pulses `Run` to launch each instruction, supplies the second word of two-word `mvi` instructions, waits for `Done`, and then advances its program counter. Fetching stops when the program end is reached or the processor stops responding.

## Interface
- `ADDR_W`, 5: ROM address width; the PC wraps modulo 2^ADDR_W.
- `LAST_ADDR`, 2^ADDR_W-1: address of the last program word; halt after the instruction occupying it completes.
- `TIMEOUT`, 15: maximum EXEC cycles to wait for `Done` before faulting.
- `Clock`  in  1  single clock; everything is rising-edge.
- `Resetn`  in  1  synchronous, active-low reset.
- `Start`  in  1  level; enables fetching.
- `MemAddr`  out  ADDR_W  ROM address.
- `MemData`  in  16  ROM data; valid one cycle after `MemAddr` is presented.
- `DIN`  out  16  word driven to the processor.
- `Run`  out  1  one-cycle launch pulse to the processor.
- `Done`  in  1  processor completion, sampled only in EXEC.
- `PC`  out  ADDR_W  address of the current or next instruction.
- `Halted`  out  1  program end reached; sticky.
- `Fault`  out  1  `Done` timeout; sticky.

## Operation
- Opcode field is `IR[8:6]`. `3'b001` (`mvi`) is two words: the instruction, then the immediate at PC+1. All other opcodes are one word.
- FSM states: IDLE, FETCH, LOAD, IMM, ISSUE, EXEC, HALT, FAULT.
- **IDLE:** `MemAddr`=PC. `Start`=1 moves to FETCH.
- **FETCH:** `MemAddr`=PC. Go to LOAD.
- **LOAD:**
  - `MemAddr`=PC+1 (mod 2^ADDR_W).
  - Capture `instr_reg`=`MemData`.
  - Go to IMM if `MemData[8:6]`==001, else go to ISSUE.
- **IMM:** capture `imm_reg`=`MemData`. Go to ISSUE.
- **ISSUE:** `DIN`=`instr_reg`, `Run`=1 for exactly this cycle. Go to EXEC. `Done` is ignored here.
- **EXEC:**
  - `Run`=0.
  - `DIN`=`imm_reg` if `mvi`, else `instr_reg`; held stable for the whole state.
  - On `Done`=1: PC advances by len (2 for `mvi`, else 1), modulo 2^ADDR_W.
  - Next state after `Done`: HALT if PC ≤ LAST_ADDR ≤ PC+len-1 (unwrapped compare on the old PC); else FETCH if `Start`=1; else IDLE.
  - If the watchdog reaches TIMEOUT without `Done`: go to FAULT; PC is unchanged.
- **HALT / FAULT:** `Run`=0, `DIN` holds its last value, the matching flag is 1. Only reset leaves these states.
- Watchdog: a 4-bit-or-wider counter, cleared on entering EXEC and incremented each EXEC cycle.
- `mvi` at address 2^ADDR_W-1 takes its immediate from address 0, because `MemAddr` wraps.
- Dropping `Start` mid-instruction does not abort it. The instruction completes, and the FSM then returns to IDLE with PC advanced.

## Timing
- Reset values (`Resetn`=0 at an edge): state IDLE, PC=0, `MemAddr`=0, `DIN`=0, `Run`=0, `Halted`=0, `Fault`=0, `instr_reg`=`imm_reg`=0, watchdog=0.
- Reset has priority over every state, including mid-EXEC and HALT/FAULT.
- Reset is synchronous only; `Resetn` is never used as an asynchronous clear.
- `Run` rises at most 3 cycles after `Start` rises for a one-word instruction, and 4 cycles for `mvi`.
- During the ISSUE cycle, `DIN` carries the instruction word; the processor samples it into its IR on that edge.
- `DIN` switches to the immediate on the first EXEC cycle, which is the processor's time step 1.
- Back-to-back throughput: `Done` in EXEC cycle k leads to the next `Run` in cycle k+3 (k+4 for `mvi`).
- If `Done` and watchdog expiry occur in the same cycle, `Done` wins.
- `Start` is sampled only in IDLE and at `Done` in EXEC.
- All outputs are registered; there is no combinational path from `Done` or `MemData` to `Run` or `DIN`.

## Test plan
- **Reset and idle:** `Resetn`=0 for 2 cycles with `Start`=0 → `MemAddr`=0, `DIN`=0, `Run`=0, `Halted`=0, `Fault`=0; the FSM stays in IDLE indefinitely.
- **One-word launch:** ROM[0]=16'h0008 (mv R1,R0), `Start`=1, `Done` returned 1 cycle after `Run` → `Run` high for one cycle, 3 cycles after `Start`; `DIN`=16'h0008 in both ISSUE and EXEC; PC=1 afterwards.
- **mvi:** ROM[0]=16'h0040, ROM[1]=16'h1234 → `DIN`=0040 in the ISSUE cycle and 1234 from the first EXEC cycle until `Done`; PC=2; the next `Run` fetches ROM[2].
- **Program end:** LAST_ADDR=3, one-word instructions at 0..3 → exactly 4 `Run` pulses, then `Halted`=1 and no further `Run`. Repeat with `mvi` at address 3 and 31 (ADDR_W=5): the immediate is read from address 0 and the FSM halts.
- **Watchdog:** `Done` held 0 after `Run` → `Fault`=1 after 15 EXEC cycles and PC is unchanged. A second run with `Done` asserted in cycle 15 must complete normally with `Fault`=0.
- **Mid-operation events:**
  - `Start` dropped during EXEC → the instruction completes, the FSM enters IDLE, and PC is advanced.
  - `Resetn`=0 during EXEC and during HALT → next cycle, all reset values hold; reasserting `Start` refetches from address 0.
